// File: rtl/jtag_pkg.sv
// Shared JTAG master definitions: command opcodes, sequencer states,
// 4-bit IEEE 1149.1 TAP state encodings and the TAP next-state function.
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_TMS   = 2'b00,
    OP_SHIFT = 2'b01,
    OP_IDLE  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_e;

  localparam logic [3:0] TAP_EX2DR   = 4'h0;
  localparam logic [3:0] TAP_EX1DR   = 4'h1;
  localparam logic [3:0] TAP_SHDR    = 4'h2;
  localparam logic [3:0] TAP_PAUSEDR = 4'h3;
  localparam logic [3:0] TAP_SELIR   = 4'h4;
  localparam logic [3:0] TAP_UPDDR   = 4'h5;
  localparam logic [3:0] TAP_CAPDR   = 4'h6;
  localparam logic [3:0] TAP_SELDR   = 4'h7;
  localparam logic [3:0] TAP_EX2IR   = 4'h8;
  localparam logic [3:0] TAP_EX1IR   = 4'h9;
  localparam logic [3:0] TAP_SHIR    = 4'hA;
  localparam logic [3:0] TAP_PAUSEIR = 4'hB;
  localparam logic [3:0] TAP_RTI     = 4'hC;
  localparam logic [3:0] TAP_UPDIR   = 4'hD;
  localparam logic [3:0] TAP_CAPIR   = 4'hE;
  localparam logic [3:0] TAP_TLR     = 4'hF;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    case (s)
      TAP_TLR:     return tms ? TAP_TLR   : TAP_RTI;
      TAP_RTI:     return tms ? TAP_SELDR : TAP_RTI;
      TAP_SELDR:   return tms ? TAP_SELIR : TAP_CAPDR;
      TAP_CAPDR:   return tms ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:    return tms ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR:   return tms ? TAP_UPDDR : TAP_PAUSEDR;
      TAP_PAUSEDR: return tms ? TAP_EX2DR : TAP_PAUSEDR;
      TAP_EX2DR:   return tms ? TAP_UPDDR : TAP_SHDR;
      TAP_UPDDR:   return tms ? TAP_SELDR : TAP_RTI;
      TAP_SELIR:   return tms ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPIR:   return tms ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:    return tms ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR:   return tms ? TAP_UPDIR : TAP_PAUSEIR;
      TAP_PAUSEIR: return tms ? TAP_EX2IR : TAP_PAUSEIR;
      TAP_EX2IR:   return tms ? TAP_UPDIR : TAP_SHIR;
      TAP_UPDIR:   return tms ? TAP_SELDR : TAP_RTI;
      default:     return TAP_TLR;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_div.sv
// TCK half-period counter: counts CLK_DIV-1..0 while run is high and
// strobes phase_end on the last clk cycle of each half-period.
module jtag_tck_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic phase_end
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !run || cnt == '0) cnt <= TOP;
    else                            cnt <= cnt - CW'(1);
  end

  assign phase_end = run && (cnt == '0);

endmodule

// File: rtl/jtag_master.sv
// JTAG initiator: runs TMS / shift / idle-clock commands on TCK/TMS/TDI and
// captures TDO. Define JTAG_TAP_TRACK_EN to mirror the target TAP state.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 4,
  localparam int LEN_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_exit,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo,
  output logic [3:0]        tap_state
);

  state_e            state;
  op_e               op_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  bit_q;
  logic              exit_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] cap_q;
  logic              tdo_meta;
  logic              tdo_sync;
  logic              phase_end;
  logic [LEN_W-1:0]  bit_nxt;

  // Returns {tms, tdi} for bit i of a command.
  function automatic logic [1:0] drive_bits(input op_e op, input logic [DATA_W-1:0] d,
                                            input logic [LEN_W-1:0] i,
                                            input logic [LEN_W-1:0] len, input logic ex);
    case (op)
      OP_TMS:   return {d[i], 1'b0};
      OP_SHIFT: return {ex && (i == len), d[i]};
      default:  return 2'b00;
    endcase
  endfunction

  assign bit_nxt = bit_q + LEN_W'(1);
  assign busy    = !cmd_ready;

  jtag_tck_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .reset     (reset),
    .run       (state == ST_LOW || state == ST_HIGH),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tdo_meta <= 1'b0;
      tdo_sync <= 1'b0;
    end else begin
      tdo_meta <= tdo;
      tdo_sync <= tdo_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= OP_TMS;
      len_q     <= '0;
      bit_q     <= '0;
      exit_q    <= 1'b0;
      data_q    <= '0;
      cap_q     <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q      <= op_e'(cmd_op);
            len_q     <= cmd_len;
            exit_q    <= cmd_exit;
            data_q    <= cmd_data;
            bit_q     <= '0;
            cap_q     <= '0;
            cmd_ready <= 1'b0;
            tck       <= 1'b0;
            // Reserved ops produce no TCK activity and leave the pins untouched.
            if (op_e'(cmd_op) == OP_RSVD) begin
              state <= ST_DONE;
            end else begin
              {tms, tdi} <= drive_bits(op_e'(cmd_op), cmd_data, '0, cmd_len, cmd_exit);
              state      <= ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (phase_end) begin
            tck   <= 1'b1;
            state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (phase_end) begin
            cap_q[bit_q] <= tdo_sync;
            tck          <= 1'b0;
            if (bit_q == len_q) begin
              state <= ST_DONE;
            end else begin
              bit_q      <= bit_nxt;
              {tms, tdi} <= drive_bits(op_q, data_q, bit_nxt, len_q, exit_q);
              state      <= ST_LOW;
            end
          end
        end
        ST_DONE: begin
          rsp_valid <= 1'b1;
          rsp_data  <= cap_q;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef JTAG_TAP_TRACK_EN
  logic [3:0] tap_q;

  // The target TAP advances on TCK rise, which happens at the end of LOW.
  always_ff @(posedge clk) begin
    if (reset)                           tap_q <= TAP_TLR;
    else if (state == ST_LOW && phase_end) tap_q <= tap_next(tap_q, tms);
  end

  assign tap_state = tap_q;
`else
  assign tap_state = TAP_TLR;
`endif

endmodule
